// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM encoding and sizing helper for the multi-cycle ALU
package alu_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;
  localparam int OP_DIV = 3;
  localparam int OP_AND = 4;
  localparam int OP_OR  = 5;
  localparam int OP_XOR = 6;
  localparam int OP_SHL = 7;
  localparam int OP_SHR = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_DIV
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - shared iterative shift-add multiplier / restoring divider
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = clog2(WIDTH) + 1;

  // acc is the product high half or the partial remainder; sr holds multiplier or dividend/quotient
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] opb;
  logic [CW-1:0]    cnt;
  logic             running;
  logic             div_mode;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH+1:0] trial;

  always_comb begin
    add_sum = {1'b0, acc} + (sr[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    trial   = {1'b0, acc, sr[WIDTH-1]} - {2'b00, opb};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      sr       <= '0;
      opb      <= '0;
      cnt      <= '0;
      running  <= 1'b0;
      div_mode <= 1'b0;
    end else if (start) begin
      acc      <= '0;
      sr       <= a;
      opb      <= b;
      cnt      <= '0;
      running  <= 1'b1;
      div_mode <= mode_div;
    end else if (running) begin
      if (cnt == CW'(WIDTH)) begin
        running <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
        if (div_mode) begin
          // trial[WIDTH+1] set means the subtraction borrowed: restore by keeping the shifted value
          if (!trial[WIDTH+1]) begin
            acc <= trial[WIDTH-1:0];
            sr  <= {sr[WIDTH-2:0], 1'b1};
          end else begin
            acc <= {acc[WIDTH-2:0], sr[WIDTH-1]};
            sr  <= {sr[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc <= add_sum[WIDTH:1];
          sr  <= {add_sum[0], sr[WIDTH-1:1]};
        end
      end
    end
  end

  assign done = running && (cnt == CW'(WIDTH));
  assign lo   = sr;
  assign hi   = acc;

endmodule

// File: rtl/alu_multiciclu.sv
// rtl/alu_multiciclu.sv - multi-cycle ALU: FSM, single-cycle ops, flags and output registers
module alu_multiciclu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPW-1:0]   operatie,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rezultat,
  output logic [WIDTH-1:0] rest_rezultat,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div0,
  output logic             op_err
);

  localparam int SW = clog2(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;
  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic             finish;
  logic             iter_done;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] res_nx;
  logic [WIDTH-1:0] rest_nx;
  logic             carry_nx;
  logic             ovf_nx;
  logic             div0_nx;
  logic             err_nx;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;

  // The done cycle still counts as busy, so a start there is dropped
  assign busy   = (state != ST_IDLE) || done;
  assign accept = start && !busy;
  assign is_mul = (int'(operatie) == OP_MUL);
  assign is_div = (int'(operatie) == OP_DIV) && (B != '0);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && (is_mul || is_div)),
    .mode_div (is_div),
    .a        (A),
    .b        (B),
    .done     (iter_done),
    .lo       (iter_lo),
    .hi       (iter_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    finish   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul)      state_nx = ST_MUL;
          else if (is_div) state_nx = ST_DIV;
          else             state_nx = ST_EXEC;
        end
      end
      ST_EXEC: begin
        finish   = 1'b1;
        state_nx = ST_IDLE;
      end
      ST_MUL, ST_DIV: begin
        if (iter_done) begin
          finish   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (accept) begin
      a_q  <= A;
      b_q  <= B;
      op_q <= operatie;
    end
  end

  always_comb begin
    res_nx   = '0;
    rest_nx  = '0;
    carry_nx = 1'b0;
    ovf_nx   = 1'b0;
    div0_nx  = 1'b0;
    err_nx   = 1'b0;
    add_full = {1'b0, a_q} + {1'b0, b_q};
    sub_full = {1'b0, a_q} - {1'b0, b_q};
    if (state == ST_MUL || state == ST_DIV) begin
      res_nx  = iter_lo;
      rest_nx = iter_hi;
    end else begin
      case (int'(op_q))
        OP_ADD: begin
          res_nx   = add_full[WIDTH-1:0];
          carry_nx = add_full[WIDTH];
          ovf_nx   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_full[WIDTH-1] != a_q[WIDTH-1]);
        end
        OP_SUB: begin
          res_nx   = sub_full[WIDTH-1:0];
          carry_nx = sub_full[WIDTH];
          ovf_nx   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_full[WIDTH-1] != a_q[WIDTH-1]);
        end
        OP_MUL: res_nx = '0;
        // Only a zero divisor reaches EXEC with a DIV opcode
        OP_DIV: begin
          res_nx  = '1;
          rest_nx = a_q;
          div0_nx = 1'b1;
        end
        OP_AND: res_nx = a_q & b_q;
        OP_OR:  res_nx = a_q | b_q;
        OP_XOR: res_nx = a_q ^ b_q;
        OP_SHL: res_nx = a_q << b_q[SW-1:0];
        OP_SHR: res_nx = a_q >> b_q[SW-1:0];
        default: err_nx = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done          <= 1'b0;
      rezultat      <= '0;
      rest_rezultat <= '0;
      zero          <= 1'b0;
      carry         <= 1'b0;
      overflow      <= 1'b0;
      div0          <= 1'b0;
      op_err        <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        rezultat      <= res_nx;
        rest_rezultat <= rest_nx;
        zero          <= (res_nx == '0);
        carry         <= carry_nx;
        overflow      <= ovf_nx;
        div0          <= div0_nx;
        op_err        <= err_nx;
      end
    end
  end

endmodule

// File: tb/tb_alu_multiciclu.sv
// tb/tb_alu_multiciclu.sv - directed and random checks of alu_multiciclu
module tb_alu_multiciclu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  operatie;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] rezultat;
  logic [31:0] rest_rezultat;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic        div0;
  logic        op_err;

  logic        s_start;
  logic [3:0]  s_op;
  logic [15:0] s_a;
  logic [15:0] s_b;
  logic        s_busy;
  logic        s_done;
  logic [15:0] s_rez;
  logic [15:0] s_rest;
  logic        s_zero;
  logic        s_carry;
  logic        s_overflow;
  logic        s_div0;
  logic        s_op_err;

  int tests;
  int failed;
  int lat;
  int pulses;

  alu_multiciclu #(.WIDTH(32), .OPW(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .operatie      (operatie),
    .A             (A),
    .B             (B),
    .busy          (busy),
    .done          (done),
    .rezultat      (rezultat),
    .rest_rezultat (rest_rezultat),
    .zero          (zero),
    .carry         (carry),
    .overflow      (overflow),
    .div0          (div0),
    .op_err        (op_err)
  );

  alu_multiciclu #(.WIDTH(16), .OPW(4)) dut16 (
    .clk           (clk),
    .rst           (rst),
    .start         (s_start),
    .operatie      (s_op),
    .A             (s_a),
    .B             (s_b),
    .busy          (s_busy),
    .done          (s_done),
    .rezultat      (s_rez),
    .rest_rezultat (s_rest),
    .zero          (s_zero),
    .carry         (s_carry),
    .overflow      (s_overflow),
    .div0          (s_div0),
    .op_err        (s_op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are scrambled after the issue cycle; only the captured copies may matter
  task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int l);
    @(negedge clk);
    start = 1'b1; operatie = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; operatie = 4'($urandom); A = $urandom; B = $urandom;
    l = 1;
    while (done !== 1'b1 && l < 200) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic run16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       output int l);
    @(negedge clk);
    s_start = 1'b1; s_op = op; s_a = a; s_b = b;
    @(negedge clk);
    s_start = 1'b0; s_op = 4'($urandom); s_a = 16'($urandom); s_b = 16'($urandom);
    l = 1;
    while (s_done !== 1'b1 && l < 200) begin
      @(negedge clk);
      l++;
    end
  endtask

  function automatic logic [36:0] model16(input int op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r, h;
    logic        c, v, e;
    logic [16:0] t;
    logic [31:0] p;
    r = '0; h = '0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (op)
      0: begin t = {1'b0, a} + {1'b0, b}; r = t[15:0]; c = t[16];
               v = (a[15] == b[15]) && (r[15] != a[15]); end
      1: begin r = a - b; c = (a < b); v = (a[15] != b[15]) && (r[15] != a[15]); end
      2: begin p = {16'd0, a} * {16'd0, b}; r = p[15:0]; h = p[31:16]; end
      3: begin r = a / b; h = a % b; end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: r = a << b[3:0];
      8: r = a >> b[3:0];
      default: e = 1'b1;
    endcase
    return {(r == 16'd0), c, v, 1'b0, e, h, r};
  endfunction

  initial begin
    logic [36:0] exp16;
    int          op_r;
    logic [15:0] ra, rb;
    tests = 0; failed = 0;
    rst = 1'b1; start = 1'b0; operatie = '0; A = '0; B = '0;
    s_start = 1'b0; s_op = '0; s_a = '0; s_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_rez", {rezultat, rest_rezultat}, 64'd0);
    check("reset_flags", {zero, carry, overflow, div0, op_err, busy, done}, 64'd0);

    run32(4'd0, 32'd5, 32'd7, lat);
    check("add_small_rez", rezultat, 32'd12);

    // Reset held for two cycles in the middle of a MUL
    @(negedge clk);
    start = 1'b1; operatie = 4'd2; A = 32'd5; B = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mul_busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_mid_rez", {rezultat, rest_rezultat}, 64'd0);
    check("rst_mid_flags", {zero, carry, overflow, div0, op_err, busy, done}, 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("rst_mid_no_done", 64'(pulses), 64'd0);

    run32(4'd0, 32'hFFFF_FFFF, 32'd1, lat);
    check("add_wrap_lat", 64'(lat), 64'd2);
    check("add_wrap_rez", {rest_rezultat, rezultat}, 64'd0);
    check("add_wrap_flags", {zero, carry, overflow, div0, op_err}, 5'b11000);

    run32(4'd0, 32'h7FFF_FFFF, 32'd1, lat);
    check("add_ovf_rez", rezultat, 32'h8000_0000);
    check("add_ovf_flags", {zero, carry, overflow, div0, op_err}, 5'b00100);

    run32(4'd1, 32'd5, 32'd7, lat);
    check("sub_borrow_rez", rezultat, 32'hFFFF_FFFE);
    check("sub_borrow_flags", {zero, carry, overflow, div0, op_err}, 5'b01000);

    run32(4'd2, 32'h0001_0000, 32'h0003_0000, lat);
    check("mul_lat", 64'(lat), 64'd34);
    check("mul_rez", {rest_rezultat, rezultat}, 64'h0000_0003_0000_0000);
    check("mul_flags", {zero, carry, overflow, div0, op_err}, 5'b10000);

    run32(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check("mul_max_rez", {rest_rezultat, rezultat}, 64'hFFFF_FFFE_0000_0001);

    run32(4'd3, 32'd100, 32'd7, lat);
    check("div_lat", 64'(lat), 64'd34);
    check("div_rez", {rest_rezultat, rezultat}, {32'd2, 32'd14});
    check("div_flags", {zero, carry, overflow, div0, op_err}, 5'b00000);

    run32(4'd3, 32'd9, 32'd0, lat);
    check("div0_lat", 64'(lat), 64'd2);
    check("div0_rez", {rest_rezultat, rezultat}, {32'd9, 32'hFFFF_FFFF});
    check("div0_flags", {zero, carry, overflow, div0, op_err}, 5'b00010);

    run32(4'd7, 32'd3, 32'h21, lat);
    check("shl_amount_masked", rezultat, 32'd6);
    run32(4'd8, 32'd96, 32'd3, lat);
    check("shr", rezultat, 32'd12);
    run32(4'd7, 32'd1, 32'd31, lat);
    check("shl_max", rezultat, 32'h8000_0000);

    run32(4'd4, 32'hF0F0, 32'hFF00, lat);
    check("and", rezultat, 32'hF000);
    run32(4'd5, 32'hF0F0, 32'hFF00, lat);
    check("or", rezultat, 32'hFFF0);
    run32(4'd6, 32'hF0F0, 32'hFF00, lat);
    check("xor", rezultat, 32'h0FF0);

    run32(4'd12, 32'd55, 32'd66, lat);
    check("illegal_rez", {rest_rezultat, rezultat}, 64'd0);
    check("illegal_flags", {zero, carry, overflow, div0, op_err}, 5'b10001);

    // A second start while a DIV is in flight must not disturb it or be queued
    @(negedge clk);
    start = 1'b1; operatie = 4'd3; A = 32'd1000; B = 32'd10;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
      start = (lat == 5); operatie = 4'd0; A = 32'd1; B = 32'd1;
    end
    start = 1'b0;
    check("busy_ignore_lat", 64'(lat), 64'd34);
    check("busy_ignore_rez", {rest_rezultat, rezultat}, {32'd0, 32'd100});
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("busy_ignore_no_queue", 64'(pulses), 64'd0);

    // Back-to-back issue: run32 raises start in the cycle right after done
    run32(4'd2, 32'd7, 32'd6, lat);
    check("b2b_first_rez", rezultat, 32'd42);
    run32(4'd1, 32'd10, 32'd3, lat);
    check("b2b_second_lat", 64'(lat), 64'd2);
    check("b2b_second_rez", rezultat, 32'd7);

    for (int i = 0; i < 24; i++) begin
      op_r = (i < 10) ? i : int'($urandom_range(0, 9));
      ra = 16'($urandom_range(1, 100));
      rb = 16'($urandom_range(1, 100));
      exp16 = model16(op_r, ra, rb);
      run16(4'(op_r), ra, rb, lat);
      check("rand16_out", {s_zero, s_carry, s_overflow, s_div0, s_op_err, s_rest, s_rez}, exp16);
      check("rand16_lat", 64'(lat), (op_r == 2 || op_r == 3) ? 64'd18 : 64'd2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
